// File: rtl/soft_reset_pkg.sv
// Shared definitions for the soft-reset controller slice.
// Holds register addresses, FSM state encoding, STATUS bit positions and
// the default key words.
package soft_reset_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ARMED        = 3'd1,
    S_FIRE_WAIT    = 3'd2,
    S_STROBE       = 3'd3,
    S_WAIT_ASSERT  = 3'd4,
    S_WAIT_RELEASE = 3'd5
  } state_e;

  localparam int unsigned STAT_BAD_KEY   = 4;
  localparam int unsigned STAT_ARM_TO    = 5;
  localparam int unsigned STAT_ASSERT_TO = 6;
  localparam int unsigned STAT_BUSY      = 7;

  localparam logic [31:0] DEF_ARM_KEY  = 32'hA5A5_0001;
  localparam logic [31:0] DEF_FIRE_KEY = 32'h5A5A_0002;

  function automatic logic is_busy(input state_e s);
    return (s == S_FIRE_WAIT) || (s == S_STROBE) ||
           (s == S_WAIT_ASSERT) || (s == S_WAIT_RELEASE);
  endfunction

endpackage

// File: rtl/soft_reset_ctrl_wb_reg_responder.sv
// wb_reg_responder: single-cycle wishbone responder for the soft-reset
// register block. Answers every request one cycle later with ack (legal
// access) or err (read of CTRL/CLEAR, write of STATUS/COUNT), muxes read
// data, and decodes the legal CTRL/CLEAR write strobes for the FSM.
// Ports:
//   clock_i, reset_i          clock, synchronous active-high reset
//   wb_req_i/we_i/addr_i      bus request
//   status_i, count_i         register contents for reads
//   ctrl_wr_o, clear_wr_o     legal write strobes (same cycle as request)
//   wb_ack_o, wb_err_o        response strobes
//   wb_data_o                 read data, zero except on read acks
module wb_reg_responder
  import soft_reset_pkg::*;
#(
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                wb_req_i,
  input  logic                wb_we_i,
  input  logic [1:0]          wb_addr_i,
  input  logic [7:0]          status_i,
  input  logic [CNT_BITS-1:0] count_i,
  output logic                ctrl_wr_o,
  output logic                clear_wr_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [31:0]         wb_data_o
);

  logic        legal;
  logic [31:0] rdata;

  always_comb begin
    legal      = 1'b0;
    rdata      = '0;
    ctrl_wr_o  = 1'b0;
    clear_wr_o = 1'b0;
    case (wb_addr_i)
      ADDR_CTRL: begin
        legal     = wb_we_i;
        ctrl_wr_o = wb_req_i & wb_we_i;
      end
      ADDR_STATUS: begin
        legal = ~wb_we_i;
        rdata = 32'(status_i);
      end
      ADDR_COUNT: begin
        legal = ~wb_we_i;
        rdata = 32'(count_i);
      end
      ADDR_CLEAR: begin
        legal      = wb_we_i;
        clear_wr_o = wb_req_i & wb_we_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_data_o <= '0;
    end else begin
      wb_ack_o  <= wb_req_i & legal;
      wb_err_o  <= wb_req_i & ~legal;
      wb_data_o <= (wb_req_i & legal & ~wb_we_i) ? rdata : '0;
    end
  end

endmodule

// File: rtl/soft_reset_ctrl.sv
// soft_reset_ctrl: register-side initiator of the soft-reset handshake.
// A keyed ARM/FIRE write pair on CTRL starts a holdoff, then a one-cycle
// soft_reset_o strobe; the generator's reset_active_i rise and fall are
// tracked, completions counted (saturating) and timeouts flagged sticky.
// Ports:
//   clock_i, reset_i          clock, synchronous active-high reset
//   wb_*                      wishbone register port (1-cycle response)
//   reset_active_i            hold-reset from the reset generator
//   soft_reset_o              one-cycle request strobe
//   busy_o                    high from FIRE ack until completion/timeout
module soft_reset_ctrl
  import soft_reset_pkg::*;
#(
  parameter logic [31:0] ARM_KEY        = DEF_ARM_KEY,
  parameter logic [31:0] FIRE_KEY       = DEF_FIRE_KEY,
  parameter int unsigned ARM_TIMEOUT    = 1023,
  parameter int unsigned FIRE_DELAY     = 15,
  parameter int unsigned ASSERT_TIMEOUT = 255,
  parameter int unsigned CNT_BITS       = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        wb_req_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_data_o,
  input  logic        reset_active_i,
  output logic        soft_reset_o,
  output logic        busy_o
);

  // One timer serves all three timed states; sized for the largest limit.
  localparam int unsigned ARM_W  = $clog2(ARM_TIMEOUT + 1);
  localparam int unsigned FD_W   = $clog2(FIRE_DELAY + 1);
  localparam int unsigned AS_W   = $clog2(ASSERT_TIMEOUT + 1);
  localparam int unsigned MAX_W0 = (ARM_W > FD_W) ? ARM_W : FD_W;
  localparam int unsigned TMR_W  = (MAX_W0 > AS_W) ? MAX_W0 : AS_W;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                bad_key_q, arm_to_q, assert_to_q;
  logic                set_bad, set_arm_to, set_assert_to, cnt_inc;
  logic [CNT_BITS-1:0] cnt_q;
  logic                ctrl_wr, clear_wr;
  logic [7:0]          status;

  assign soft_reset_o = (state_q == S_STROBE);
  assign busy_o       = is_busy(state_q);
  assign status       = {busy_o, assert_to_q, arm_to_q, bad_key_q, 1'b0, state_q};

  wb_reg_responder #(.CNT_BITS(CNT_BITS)) u_resp (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .wb_req_i   (wb_req_i),
    .wb_we_i    (wb_we_i),
    .wb_addr_i  (wb_addr_i),
    .status_i   (status),
    .count_i    (cnt_q),
    .ctrl_wr_o  (ctrl_wr),
    .clear_wr_o (clear_wr),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .wb_data_o  (wb_data_o)
  );

  always_comb begin
    state_d       = state_q;
    tmr_d         = '0;
    set_bad       = 1'b0;
    set_arm_to    = 1'b0;
    set_assert_to = 1'b0;
    cnt_inc       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_wr) begin
          if (wb_data_i == ARM_KEY) state_d = S_ARMED;
          else                      set_bad = 1'b1;
        end
      end
      // A CTRL write is evaluated before the timeout check.
      S_ARMED: begin
        if (ctrl_wr) begin
          if (wb_data_i == FIRE_KEY) begin
            state_d = S_FIRE_WAIT;
          end else if (wb_data_i != ARM_KEY) begin
            set_bad = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tmr_q == TMR_W'(ARM_TIMEOUT)) begin
          set_arm_to = 1'b1;
          state_d    = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_FIRE_WAIT: begin
        if (tmr_q == TMR_W'(FIRE_DELAY)) state_d = S_STROBE;
        else                             tmr_d   = tmr_q + TMR_W'(1);
      end
      S_STROBE: begin
        state_d = reset_active_i ? S_WAIT_RELEASE : S_WAIT_ASSERT;
      end
      S_WAIT_ASSERT: begin
        if (reset_active_i) begin
          state_d = S_WAIT_RELEASE;
        end else if (tmr_q == TMR_W'(ASSERT_TIMEOUT)) begin
          set_assert_to = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_WAIT_RELEASE: begin
        if (!reset_active_i) begin
          cnt_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      bad_key_q   <= 1'b0;
      arm_to_q    <= 1'b0;
      assert_to_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      // Set dominates a simultaneous CLEAR.
      bad_key_q   <= set_bad       | (bad_key_q   & ~clear_wr);
      arm_to_q    <= set_arm_to    | (arm_to_q    & ~clear_wr);
      assert_to_q <= set_assert_to | (assert_to_q & ~clear_wr);
      if (cnt_inc && (cnt_q != '1)) cnt_q <= cnt_q + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_soft_reset_ctrl.sv
module tb_soft_reset_ctrl;

  localparam logic [1:0]  A_CTRL   = 2'd0;
  localparam logic [1:0]  A_STATUS = 2'd1;
  localparam logic [1:0]  A_COUNT  = 2'd2;
  localparam logic [1:0]  A_CLEAR  = 2'd3;
  localparam logic [31:0] K_ARM    = 32'hA5A5_0001;
  localparam logic [31:0] K_FIRE   = 32'h5A5A_0002;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        ack, err;
  logic [31:0] rdata;
  logic        active;
  logic        strobe, busy;

  int unsigned cyc = 0;
  int unsigned strobe_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int unsigned cyc;
  } rsp_t;
  rsp_t exp_q[$];
  rsp_t e;

  soft_reset_ctrl #(.CNT_BITS(2)) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .wb_req_i       (req),
    .wb_we_i        (we),
    .wb_addr_i      (addr),
    .wb_data_i      (wdata),
    .wb_ack_o       (ack),
    .wb_err_o       (err),
    .wb_data_o      (rdata),
    .reset_active_i (active),
    .soft_reset_o   (strobe),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every response strobe is matched against the queue.
  always @(negedge clk) begin
    if (ack === 1'b1 || err === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got ack=%0b err=%0b expected none", ack, err);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", err, e.err);
        check("rsp_ack", ack, !e.err);
        check("rsp_data", rdata, e.data);
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic exp_err, input logic [31:0] exp_d);
    rsp_t r;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    r.err = exp_err; r.data = exp_d; r.cyc = cyc + 1;
    exp_q.push_back(r);
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic exp_err);
    bus(1'b1, a, d, exp_err, 32'h0);
  endtask

  task automatic rd(input logic [1:0] a, input logic exp_err, input logic [31:0] exp_d);
    bus(1'b0, a, 32'h0, exp_err, exp_d);
  endtask

  task automatic wait_strobe(output int unsigned sc);
    logic found;
    found = 1'b0;
    sc = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (strobe === 1'b1) begin
        found = 1'b1;
        sc = cyc;
      end
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL strobe_timeout: got no strobe expected one within 100 cycles");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned a_cyc, s_cyc, base;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; active = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_data", rdata, 0);
    check("rst_strobe", strobe, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Normal sequence
    rd(A_STATUS, 0, 32'h0);
    rd(A_COUNT, 0, 32'h0);
    wr(A_CTRL, K_ARM, 0);
    repeat (8) @(negedge clk);
    wr(A_CTRL, K_FIRE, 0);
    a_cyc = cyc;
    check("busy_at_fire_ack", busy, 1);
    wait_strobe(s_cyc);
    check("strobe_latency", s_cyc - a_cyc, 16);
    @(negedge clk);
    check("strobe_one_cycle", strobe, 0);
    repeat (4) @(negedge clk);
    active = 1'b1;
    repeat (300) @(negedge clk);
    check("busy_in_hold", busy, 1);
    active = 1'b0;
    @(negedge clk);
    check("busy_after_release", busy, 0);
    rd(A_STATUS, 0, 32'h0);
    rd(A_COUNT, 0, 32'd1);
    check("strobes_s1", strobe_cnt, 1);

    // Arm timeout; re-arm exactly at the expiry cycle wins
    wr(A_CTRL, K_ARM, 0);
    repeat (1022) @(negedge clk);
    wr(A_CTRL, K_ARM, 0);
    rd(A_STATUS, 0, 32'h01);
    repeat (1000) @(negedge clk);
    rd(A_STATUS, 0, 32'h01);
    repeat (30) @(negedge clk);
    rd(A_STATUS, 0, 32'h20);
    wr(A_CTRL, K_FIRE, 0);
    rd(A_STATUS, 0, 32'h30);
    repeat (30) @(negedge clk);
    check("no_strobe_bad_fire", strobe_cnt, 1);
    wr(A_CLEAR, 32'h0, 0);
    rd(A_STATUS, 0, 32'h0);

    // Assert timeout and error responses
    wr(A_CTRL, K_ARM, 0);
    wr(A_CTRL, K_FIRE, 0);
    wait_strobe(s_cyc);
    repeat (256) @(negedge clk);
    check("busy_last_assert_wait", busy, 1);
    @(negedge clk);
    check("busy_after_assert_to", busy, 0);
    rd(A_STATUS, 0, 32'h40);
    rd(A_CTRL, 1, 32'h0);
    rd(A_CLEAR, 1, 32'h0);
    wr(A_COUNT, 32'h1, 1);
    wr(A_STATUS, 32'h1, 1);
    wr(A_CLEAR, 32'hFFFF_FFFF, 0);
    rd(A_STATUS, 0, 32'h0);

    // Writes while in WAIT_RELEASE are acked and ignored
    wr(A_CTRL, K_ARM, 0);
    wr(A_CTRL, K_FIRE, 0);
    wait_strobe(s_cyc);
    repeat (2) @(negedge clk);
    active = 1'b1;
    repeat (5) @(negedge clk);
    wr(A_CTRL, K_FIRE, 0);
    wr(A_CTRL, 32'h0000_1234, 0);
    rd(A_STATUS, 0, 32'h85);
    repeat (40) @(negedge clk);
    check("no_second_strobe", strobe_cnt, 3);
    active = 1'b0;
    @(negedge clk);
    check("busy_after_release2", busy, 0);
    rd(A_STATUS, 0, 32'h0);
    rd(A_COUNT, 0, 32'd2);

    // Generator already holding at strobe exit; counter saturates at 3
    for (int k = 0; k < 2; k++) begin
      active = 1'b1;
      wr(A_CTRL, K_ARM, 0);
      wr(A_CTRL, K_FIRE, 0);
      wait_strobe(s_cyc);
      rd(A_STATUS, 0, 32'h85);
      active = 1'b0;
      @(negedge clk);
      check("busy_after_fast_release", busy, 0);
      rd(A_COUNT, 0, 32'd3);
    end

    // Reset during FIRE_WAIT
    wr(A_CTRL, K_ARM, 0);
    wr(A_CTRL, K_FIRE, 0);
    repeat (5) @(negedge clk);
    base = strobe_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_strobe", strobe, 0);
    check("midrst_ack", ack, 0);
    check("midrst_err", err, 0);
    check("midrst_data", rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_strobe", strobe_cnt, base);
    rd(A_COUNT, 0, 32'd0);
    rd(A_STATUS, 0, 32'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
